// File: rtl/urisc_loader_if.sv
// Byte-stream, URISC-side and RAM-side bus bundle for the loader.
// The loader is the slave; the surrounding system (stream source, CPU, RAM) is the master.
interface urisc_loader_if;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       IN_READY;

    logic       CPU_CSMR;
    logic       CPU_WRITE;
    logic       CPU_RDMR;
    logic [7:0] CPU_ADDRESS;
    logic [7:0] CPU_WDATA;

    logic       CSMR;
    logic       WRITE;
    logic       RDMR;
    logic [7:0] ADDRESS;
    logic [7:0] WDATA;

    modport master (
        output IN_VALID, IN_DATA,
        output CPU_CSMR, CPU_WRITE, CPU_RDMR, CPU_ADDRESS, CPU_WDATA,
        input  IN_READY,
        input  CSMR, WRITE, RDMR, ADDRESS, WDATA
    );

    modport slave (
        input  IN_VALID, IN_DATA,
        input  CPU_CSMR, CPU_WRITE, CPU_RDMR, CPU_ADDRESS, CPU_WDATA,
        output IN_READY,
        output CSMR, WRITE, RDMR, ADDRESS, WDATA
    );
endinterface

// File: rtl/urisc_loader.sv
// Boot loader for a URISC core: streams a length-prefixed, checksummed image into RAM,
// then hands the RAM bus to the CPU and raises RUN.
module urisc_loader #(
    parameter logic [7:0] MEM_BASE = 8'h00
) (
    input  logic           clk_PH1,
    input  logic           rst_n,
    input  logic           LOAD,
    urisc_loader_if.slave  bus,
    output logic           RUN,
    output logic           BUSY,
    output logic           ERR
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        CHK  = 3'd4,
        EXEC = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] cnt_q,   cnt_d;    // 1..256 bytes
    logic [8:0] idx_q,   idx_d;
    logic [7:0] sum_q,   sum_d;
    logic [7:0] byte_q,  byte_d;
    logic       err_q,   err_d;

    logic       in_ready;
    logic       take;
    logic       pass;
    logic       csmr, write, rdmr;
    logic [7:0] address, wdata;

    assign take = bus.IN_VALID && in_ready;

    always_ff @(posedge clk_PH1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            byte_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        byte_d   = byte_q;
        err_d    = err_q;
        in_ready = 1'b0;
        pass     = 1'b0;
        RUN      = 1'b0;
        BUSY     = 1'b1;
        csmr     = 1'b0;
        write    = 1'b0;
        rdmr     = 1'b0;
        address  = '0;
        wdata    = '0;

        case (state_q)
            IDLE: begin
                // A failed load keeps the bus parked so the CPU cannot run stale RAM.
                if (!err_q) begin
                    BUSY = 1'b0;
                    pass = 1'b1;
                end
                if (LOAD) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            LEN: begin
                in_ready = 1'b1;
                if (take) begin
                    cnt_d   = (bus.IN_DATA == 8'h00) ? 9'd256 : {1'b0, bus.IN_DATA};
                    state_d = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (take) begin
                    byte_d  = bus.IN_DATA;
                    sum_d   = sum_q + bus.IN_DATA;
                    state_d = WR;
                end
            end
            WR: begin
                csmr    = 1'b1;
                write   = 1'b1;
                address = MEM_BASE + idx_q[7:0];
                wdata   = byte_q;
                idx_d   = idx_q + 9'd1;
                state_d = (idx_q + 9'd1 == cnt_q) ? CHK : DATA;
            end
            CHK: begin
                in_ready = 1'b1;
                if (take) begin
                    if (bus.IN_DATA == sum_q) begin
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            EXEC: begin
                RUN  = 1'b1;
                BUSY = 1'b0;
                // On reload the CPU access of this cycle must not land in RAM.
                if (LOAD) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                end else begin
                    pass = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pass) begin
            csmr    = bus.CPU_CSMR;
            write   = bus.CPU_WRITE;
            rdmr    = bus.CPU_RDMR;
            address = bus.CPU_ADDRESS;
            wdata   = bus.CPU_WDATA;
        end
    end

    assign ERR          = err_q;
    assign bus.IN_READY = in_ready;
    assign bus.CSMR     = csmr;
    assign bus.WRITE    = write;
    assign bus.RDMR     = rdmr;
    assign bus.ADDRESS  = address;
    assign bus.WDATA    = wdata;

endmodule

// File: tb/tb_urisc_loader.sv
// Directed + randomized bench for urisc_loader: a RAM model captures writes and a
// queue-based image model predicts RAM contents, RUN and ERR for each load.
module tb_urisc_loader;
    localparam logic [7:0] BASE = 8'hF0;

    logic clk_PH1 = 1'b0;
    logic rst_n   = 1'b1;
    logic LOAD    = 1'b0;
    logic RUN, BUSY, ERR;

    int total = 0;
    int bad   = 0;

    urisc_loader_if bus ();

    urisc_loader #(.MEM_BASE(BASE)) dut (
        .clk_PH1 (clk_PH1),
        .rst_n   (rst_n),
        .LOAD    (LOAD),
        .bus     (bus),
        .RUN     (RUN),
        .BUSY    (BUSY),
        .ERR     (ERR)
    );

    always #5 clk_PH1 = ~clk_PH1;

    logic [7:0] mem [256];
    int         wr_cnt    = 0;
    logic [7:0] last_addr = 8'h00;

    always @(posedge clk_PH1) begin
        if (bus.CSMR && bus.WRITE) begin
            mem[bus.ADDRESS] <= bus.WDATA;
            last_addr        <= bus.ADDRESS;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, sim stopped");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte from a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = b;
        while (bus.IN_READY !== 1'b1 && t < 20) begin
            @(negedge clk_PH1);
            t++;
        end
        total++;
        assert (t < 20) else begin
            bad++;
            $error("FAIL send_timeout: waited %0d cycles want <20", t);
        end
        @(posedge clk_PH1);
        @(negedge clk_PH1);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic pulse_load();
        LOAD = 1'b1;
        @(negedge clk_PH1);
        LOAD = 1'b0;
    endtask

    // Full load transaction checked against the image model.
    task automatic run_load(input logic [7:0] len, input logic [7:0] img [$], input logic [7:0] cs);
        int         n, w0;
        logic [7:0] s;
        bit         ok;
        n  = (len == 8'h00) ? 256 : int'(len);
        s  = 8'h00;
        for (int i = 0; i < n; i++) s = s + img[i];
        ok = (cs == s);
        w0 = wr_cnt;
        pulse_load();
        send(len);
        for (int i = 0; i < n; i++) send(img[i]);
        chk("run_before_chk", RUN, 1'b0);
        chk("busy_loading", BUSY, 1'b1);
        send(cs);
        chk("run_after_chk", RUN, ok);
        chk("err_after_chk", ERR, !ok);
        chk("busy_after_chk", BUSY, !ok);
        chk("ready_after_chk", bus.IN_READY, 1'b0);
        chk("write_count", wr_cnt - w0, n);
        for (int i = 0; i < n; i++) chk("ram", mem[BASE + 8'(i)], img[i]);
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] s, old;
        int         acc, w0, len;

        bus.IN_VALID    = 1'b0;
        bus.IN_DATA     = 8'h00;
        bus.CPU_CSMR    = 1'b1;
        bus.CPU_WRITE   = 1'b0;
        bus.CPU_RDMR    = 1'b1;
        bus.CPU_ADDRESS = 8'h5C;
        bus.CPU_WDATA   = 8'hA7;

        // Reset: idle outputs and CPU pass-through.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_run", RUN, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_ready", bus.IN_READY, 1'b0);
        chk("rst_pass_csmr", bus.CSMR, 1'b1);
        chk("rst_pass_rdmr", bus.RDMR, 1'b1);
        chk("rst_pass_addr", bus.ADDRESS, 8'h5C);
        chk("rst_pass_wdata", bus.WDATA, 8'hA7);
        @(negedge clk_PH1);
        @(negedge clk_PH1);
        rst_n = 1'b1;
        bus.CPU_CSMR = 1'b0;
        bus.CPU_RDMR = 1'b0;
        bus.IN_VALID = 1'b1;
        repeat (3) @(negedge clk_PH1);
        chk("idle_no_ready", bus.IN_READY, 1'b0);
        chk("idle_busy", BUSY, 1'b0);
        bus.IN_VALID = 1'b0;

        // Nominal image.
        q = {8'h11, 8'h22, 8'h33};
        run_load(8'h03, q, 8'h66);

        // EXEC pass-through with random CPU traffic.
        repeat (4) begin
            bus.CPU_CSMR    = 1'($urandom);
            bus.CPU_WRITE   = 1'b0;
            bus.CPU_RDMR    = 1'($urandom);
            bus.CPU_ADDRESS = 8'($urandom);
            bus.CPU_WDATA   = 8'($urandom);
            #1;
            chk("exec_csmr", bus.CSMR, bus.CPU_CSMR);
            chk("exec_rdmr", bus.RDMR, bus.CPU_RDMR);
            chk("exec_addr", bus.ADDRESS, bus.CPU_ADDRESS);
            chk("exec_wdata", bus.WDATA, bus.CPU_WDATA);
            chk("exec_busy", BUSY, 1'b0);
            @(negedge clk_PH1);
        end

        // Reload while running: the CPU write in the LOAD cycle is dropped.
        bus.CPU_CSMR    = 1'b1;
        bus.CPU_WRITE   = 1'b1;
        bus.CPU_RDMR    = 1'b0;
        bus.CPU_ADDRESS = BASE;
        bus.CPU_WDATA   = 8'hEE;
        LOAD            = 1'b1;
        #1;
        chk("reload_no_csmr", bus.CSMR, 1'b0);
        chk("reload_no_write", bus.WRITE, 1'b0);
        @(posedge clk_PH1);
        #1;
        chk("reload_run_drop", RUN, 1'b0);
        chk("reload_busy", BUSY, 1'b1);
        chk("reload_ready", bus.IN_READY, 1'b1);
        @(negedge clk_PH1);
        LOAD          = 1'b0;
        bus.CPU_CSMR  = 1'b0;
        bus.CPU_WRITE = 1'b0;
        chk("reload_write_dropped", mem[BASE], 8'h11);
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        s = 8'h00;
        foreach (q[i]) s = s + q[i];
        run_load(8'h05, q, s);

        // Checksum failure leaves ERR set and the bus parked.
        q = {8'h10, 8'h20};
        run_load(8'h02, q, 8'h31);
        bus.CPU_CSMR  = 1'b1;
        bus.CPU_WRITE = 1'b1;
        #1;
        chk("err_bus_parked", bus.CSMR, 1'b0);
        chk("err_busy", BUSY, 1'b1);
        @(negedge clk_PH1);
        chk("err_sticky", ERR, 1'b1);
        bus.CPU_CSMR  = 1'b0;
        bus.CPU_WRITE = 1'b0;

        // Random images, some with corrupted checksums.
        repeat (6) begin
            len = $urandom_range(1, 12);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            s = 8'h00;
            foreach (q[i]) s = s + q[i];
            if ($urandom_range(0, 2) == 0) s = s ^ 8'($urandom_range(1, 255));
            run_load(8'(len), q, s);
        end

        // Back-pressure: constant byte held valid, one accept per two cycles.
        pulse_load();
        send(8'd10);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 8'h5A;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.IN_READY === 1'b1) acc++;
            @(negedge clk_PH1);
        end
        chk("bp_accepts", acc, 10);
        send(8'h84);
        chk("bp_run", RUN, 1'b1);
        for (int i = 0; i < 10; i++) chk("bp_ram", mem[BASE + 8'(i)], 8'h5A);

        // Full-length image wrapping the address space.
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        run_load(8'h00, q, 8'h80);
        chk("wrap_last_addr", last_addr, 8'hEF);

        // Reset in the middle of a write cycle.
        pulse_load();
        send(8'd10);
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i));
        chk("mid_wr_write", bus.WRITE, 1'b1);
        chk("mid_wr_addr", bus.ADDRESS, BASE + 8'd5);
        old = mem[BASE + 8'd5];
        w0  = wr_cnt;
        bus.CPU_ADDRESS = 8'h3C;
        rst_n = 1'b0;
        #1;
        chk("arst_run", RUN, 1'b0);
        chk("arst_busy", BUSY, 1'b0);
        chk("arst_err", ERR, 1'b0);
        chk("arst_ready", bus.IN_READY, 1'b0);
        chk("arst_csmr", bus.CSMR, 1'b0);
        chk("arst_addr", bus.ADDRESS, 8'h3C);
        @(negedge clk_PH1);
        @(negedge clk_PH1);
        chk("arst_no_write", wr_cnt - w0, 0);
        chk("arst_ram_kept", mem[BASE + 8'd5], old);
        rst_n = 1'b1;
        bus.IN_VALID = 1'b1;
        repeat (3) @(negedge clk_PH1);
        chk("post_rst_idle", bus.IN_READY, 1'b0);
        bus.IN_VALID = 1'b0;
        q = {8'h01, 8'h02, 8'h03, 8'h04};
        run_load(8'h04, q, 8'h0A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
